// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC operand feeder.
package mac_pkg;
   localparam int OP_W        = 64;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_MAC_LAT = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_CLEAR} state_t;

   // One queued operand pair; last closes the current accumulation batch.
   typedef struct packed {
      logic            last;
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } entry_t;
endpackage

// File: rtl/mac_operand_fifo.sv
// Show-ahead operand FIFO: head entry is visible on o_data whenever non-empty.
module mac_operand_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_empty,
   output logic         o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rptr];

   // Storage needs no reset: it is only read behind a non-zero count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

// File: rtl/mac_feeder_64.sv
// Feeds queued operand pairs to a fixed-latency MAC, drains and clears per batch.
module mac_feeder_64
   import mac_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int MAC_LAT = DEF_MAC_LAT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] in_a,
   input  logic [OP_W-1:0] in_b,
   input  logic            in_last,
   output logic [OP_W-1:0] mac_a,
   output logic [OP_W-1:0] mac_b,
   output logic            mac_clr,
   output logic            res_valid,
   output logic            res_last,
   output logic            busy
);
   localparam int CW = $clog2(MAC_LAT + 1);

   state_t           r_state;
   state_t           w_nxt;
   entry_t           w_in;
   entry_t           w_head;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             r_up;
   logic [CW-1:0]    r_dcnt;
   logic [OP_W-1:0]  r_mac_a;
   logic [OP_W-1:0]  r_mac_b;
   logic             r_clr;
   // Index 0 marks the pair currently on mac_a/mac_b; index MAC_LAT is the result.
   logic [MAC_LAT:0] r_vld_pipe;
   logic [MAC_LAT:0] r_last_pipe;

   assign w_in      = {in_last, in_a, in_b};
   assign in_ready  = r_up & ~w_full;
   assign w_push    = in_valid & in_ready;
   assign mac_a     = r_mac_a;
   assign mac_b     = r_mac_b;
   assign mac_clr   = r_clr;
   assign res_valid = r_vld_pipe[MAC_LAT];
   assign res_last  = r_vld_pipe[MAC_LAT] & r_last_pipe[MAC_LAT];
   assign busy      = (r_state != ST_IDLE);

   mac_operand_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(entry_t))
   ) u_fifo (
      .clk     (clk),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_data  (w_in),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // Next state and pop. IDLE issues its first pair directly so a pair pushed
   // into an idle block reaches the MAC one cycle later.
   always_comb begin
      w_nxt = r_state;
      w_pop = 1'b0;
      case (r_state)
         ST_IDLE, ST_RUN: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               w_nxt = w_head.last ? ST_DRAIN : ST_RUN;
            end
         end
         ST_DRAIN: if (r_dcnt == CW'(MAC_LAT - 1)) w_nxt = ST_CLEAR;
         ST_CLEAR: w_nxt = ST_IDLE;
         default:  w_nxt = ST_IDLE;
      endcase
   end

   // State, drain counter, ready enable and registered clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_dcnt  <= '0;
         r_up    <= 1'b0;
         r_clr   <= 1'b1;
      end else begin
         r_state <= w_nxt;
         r_dcnt  <= (r_state == ST_DRAIN) ? r_dcnt + 1'b1 : '0;
         r_up    <= 1'b1;
         r_clr   <= (w_nxt == ST_CLEAR);
      end
   end

   // Issue registers: popped operands, zeros on every non-issue cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mac_a <= '0;
         r_mac_b <= '0;
      end else begin
         r_mac_a <= w_pop ? w_head.a : '0;
         r_mac_b <= w_pop ? w_head.b : '0;
      end
   end

   // Result tracker; wiped while the MAC is being cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
      end else if (r_clr) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
      end else begin
         r_vld_pipe  <= {r_vld_pipe[MAC_LAT-1:0], w_pop};
         r_last_pipe <= {r_last_pipe[MAC_LAT-1:0], w_pop & w_head.last};
      end
   end
endmodule

// File: doc/mac_feeder_64.md
MAC_FEEDER_64 -- requirements
Module: mac_feeder_64

Interface
REQ-001 Parameter DEPTH, default 4: operand FIFO entries; power of two, minimum 2.
REQ-002 Parameter MAC_LAT, default 4: cycles from operands presented on mac_a/mac_b to the MAC accumulator output updating.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset for the whole block.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  block can accept a pair.
REQ-007 in_a  input  64  operand A.
REQ-008 in_b  input  64  operand B.
REQ-009 in_last  input  1  final pair of the current batch.
REQ-010 mac_a  output  64  registered operand A to the MAC.
REQ-011 mac_b  output  64  registered operand B to the MAC.
REQ-012 mac_clr  output  1  registered synchronous active-high clear to the MAC.
REQ-013 res_valid  output  1  one-cycle pulse: MAC accumulator now reflects an issued pair.
REQ-014 res_last  output  1  qualifies res_valid; the pair was the batch's last.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FIFO: DEPTH entries of {a, b, last}; in_ready = not full; a push occurs when in_valid and in_ready are both high.
REQ-017 Simultaneous push and pop when full: in_ready stays low, so no push occurs; when empty, a pushed entry is not popped in the same cycle.
REQ-018 Pointers wrap modulo DEPTH; occupancy counter width is clog2(DEPTH)+1.
REQ-019 States: IDLE, RUN, DRAIN, CLEAR.
REQ-020 IDLE -> RUN when the FIFO is non-empty.
REQ-021 RUN: pop one entry per cycle while non-empty, registering mac_a/mac_b from it; issue bubbles when empty, with mac_a and mac_b driven to 0 so the MAC pipeline sees zeros.
REQ-022 RUN -> DRAIN on the cycle an entry with last=1 is popped; no further pops occur until CLEAR completes.
REQ-023 DRAIN: count MAC_LAT cycles, drive mac_a and mac_b to 0, then -> CLEAR.
REQ-024 CLEAR: mac_clr high for exactly one cycle, then -> IDLE; pushes remain allowed throughout.
REQ-025 Latency: a MAC_LAT-deep shift register of {valid, last} tracks each issue; res_valid/res_last equal its tail, asserting exactly MAC_LAT cycles after the cycle mac_a carries the pair.
REQ-026 Bubbles shift valid=0 through the tracker.
REQ-027 The tracker is cleared in the cycle mac_clr is high.
REQ-028 res_last asserts only together with res_valid.
REQ-029 Widths: operands are passed unmodified; the block performs no arithmetic on data.

Reset
REQ-030 When reset is low: FIFO empty, pointers 0, state IDLE, tracker zero, mac_a=0, mac_b=0, mac_clr=1, res_valid=0, res_last=0, busy=0.
REQ-031 in_ready is 0 while reset is asserted and 1 from the first clock edge after reset deasserts.
REQ-032 mac_clr drops on the first clock edge after reset deasserts, and the MAC is held clear throughout reset.
REQ-033 Reset asserted mid-batch discards the FIFO contents and in-flight tracker entries immediately; no res_valid is produced for them.

Structure
REQ-034 A shared package mac_pkg holds the state enum, default DEPTH/MAC_LAT constants and operand width 64.
REQ-035 The FIFO is a sub-module mac_operand_fifo, parameterised by DEPTH and entry width; the FSM, issue registers and tracker live in mac_feeder_64.

Verification
REQ-036 After reset, push (3,5),(2,7,last) back-to-back -> mac_a=3,b=5 one cycle after the first push; res_valid at issue+4 and issue+5, the second with res_last=1; mac_clr pulses 4 cycles after the last issue; busy falls the cycle after.
REQ-037 Push 6 pairs with in_valid held high, no last -> in_ready low once 4 entries are held; all 6 issue in order with no loss or duplication.
REQ-038 Gap of 3 idle cycles between pairs in RUN -> mac_a=mac_b=0 during the gaps; no res_valid pulses for the bubbles.
REQ-039 Assert reset two cycles after issuing a last pair -> no res_valid follows; after release, state IDLE and in_ready=1.
REQ-040 Push a new pair during DRAIN -> the pair is held in the FIFO, not issued until after the mac_clr cycle, and its res_valid appears MAC_LAT cycles after its issue.
